pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline (F, D, E, M, W). Merges the hazard unit's load-use stall and branch flush requests with instruction- and data-memory handshakes. Drives per-stage stall and flush controls under a fixed priority. Tracks multi-cycle data-memory waits and branch redirect windows with an FSM, and flags data-memory timeouts.

---
 rtl/pipeline_ctrl_pkg.sv | 47 ++++
 rtl/pipeline_ctrl_if.sv | 31 +++
 rtl/pipeline_ctrl_sat_counter.sv | 24 ++
 rtl/pipeline_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, per-stage control word,
// counter widths and the RUN-mode priority encoder for branch/load-use/fetch requests.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        REDIRECT  = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic stallF;
        logic stallD;
        logic stallE;
        logic stallM;
        logic flushD;
        logic flushE;
        logic flushW;
    } pipe_ctl_t;

    localparam int RDR_CNT_W  = 4;
    localparam int WAIT_CNT_W = 8;

    localparam pipe_ctl_t CTL_NONE      = 7'b0000_000;
    localparam pipe_ctl_t CTL_DMEM_HOLD = 7'b1111_001;
    localparam pipe_ctl_t CTL_RESET     = 7'b0000_111;

    // Lower-priority requests, applied whenever no data-memory stall is in force.
    function automatic pipe_ctl_t run_rules(input logic i_flush, input logic i_stall,
                                            input logic i_imem_ready);
        pipe_ctl_t ctl;
        ctl = CTL_NONE;
        if (i_flush) begin
            ctl.flushD = 1'b1;
            ctl.flushE = 1'b1;
        end else if (i_stall) begin
            ctl.stallF = 1'b1;
            ctl.stallD = 1'b1;
            ctl.flushE = 1'b1;
        end else if (!i_imem_ready) begin
            ctl.stallF = 1'b1;
            ctl.flushD = 1'b1;
        end
        return ctl;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Request/control bundle between the pipeline datapath (master) and the stall/flush
// sequencer (slave).
interface pipeline_ctrl_if;

    logic stall_req;
    logic flush_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;

    logic stallF;
    logic stallD;
    logic stallE;
    logic stallM;
    logic flushD;
    logic flushE;
    logic flushW;
    logic dmem_err;
    logic busy;

    modport master (
        output stall_req, flush_req, imem_ready, dmem_req, dmem_ready,
        input  stallF, stallD, stallE, stallM, flushD, flushE, flushW, dmem_err, busy
    );

    modport slave (
        input  stall_req, flush_req, imem_ready, dmem_req, dmem_ready,
        output stallF, stallD, stallE, stallM, flushD, flushE, flushW, dmem_err, busy
    );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Latency: count visible the cycle after i_inc; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the F/D/E/M/W pipeline; controls are combinational (same-cycle).
// Optional perf counters (stall_cycles, flush_events) when PIPELINE_CTRL_PERF_EN is defined.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REDIRECT_CYCLES = 1,
    parameter int DMEM_TIMEOUT    = 64
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    parameter int CNT_W           = 32
`endif
) (
    input  logic               clk,
    input  logic               reset,
    pipeline_ctrl_if.slave     bus
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   flush_events
`endif
);

    localparam logic [RDR_CNT_W-1:0]  RDR_LOAD  = RDR_CNT_W'(REDIRECT_CYCLES - 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX  = WAIT_CNT_W'(DMEM_TIMEOUT);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(DMEM_TIMEOUT - 1);
    localparam ctrl_state_t           FLUSH_NXT = (REDIRECT_CYCLES > 1) ? REDIRECT : RUN;

    ctrl_state_t            r_state;
    ctrl_state_t            w_state_nxt;
    logic [RDR_CNT_W-1:0]   r_rdr_cnt;
    logic [RDR_CNT_W-1:0]   w_rdr_nxt;
    logic [WAIT_CNT_W-1:0]  w_wait_cnt;
    logic                   w_wait_inc;
    logic                   w_wait_clr;
    logic                   w_dmem_miss;
    logic                   r_dmem_err;
    pipe_ctl_t              w_ctl;
    pipe_ctl_t              w_ctl_out;

    assign w_dmem_miss = bus.dmem_req & ~bus.dmem_ready;

    always_comb begin
        w_ctl       = CTL_NONE;
        w_state_nxt = r_state;
        w_rdr_nxt   = r_rdr_cnt;
        w_wait_inc  = 1'b0;
        w_wait_clr  = 1'b1;
        case (r_state)
            RUN, REDIRECT: begin
                if (w_dmem_miss) begin
                    // Wait counter is zero outside DMEM_WAIT, so one increment loads it with 1.
                    w_ctl       = CTL_DMEM_HOLD;
                    w_state_nxt = DMEM_WAIT;
                    w_rdr_nxt   = '0;
                    w_wait_inc  = 1'b1;
                    w_wait_clr  = 1'b0;
                end else if (bus.flush_req) begin
                    w_ctl       = run_rules(1'b1, bus.stall_req, bus.imem_ready);
                    w_state_nxt = FLUSH_NXT;
                    w_rdr_nxt   = RDR_LOAD;
                end else if (r_state == REDIRECT) begin
                    w_ctl.flushD = 1'b1;
                    w_rdr_nxt    = r_rdr_cnt - RDR_CNT_W'(1);
                    if (r_rdr_cnt == RDR_CNT_W'(1)) begin
                        w_state_nxt = RUN;
                    end
                end else begin
                    w_ctl = run_rules(1'b0, bus.stall_req, bus.imem_ready);
                end
            end
            DMEM_WAIT: begin
                if (!bus.dmem_ready) begin
                    w_ctl      = CTL_DMEM_HOLD;
                    w_wait_inc = (w_wait_cnt != WAIT_MAX);
                    w_wait_clr = 1'b0;
                end else begin
                    // Requests held during the wait are honoured once, on release.
                    w_ctl = run_rules(bus.flush_req, bus.stall_req, bus.imem_ready);
                    if (bus.flush_req) begin
                        w_state_nxt = FLUSH_NXT;
                        w_rdr_nxt   = RDR_LOAD;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_rdr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RUN;
            r_rdr_cnt  <= '0;
            r_dmem_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rdr_cnt <= w_rdr_nxt;
            if (w_wait_inc && (w_wait_cnt == WAIT_LAST)) begin
                r_dmem_err <= 1'b1;
            end
        end
    end

    sat_counter #(.W(WAIT_CNT_W)) u_wait_cnt (
        .clk   (clk),
        .i_clr (reset | w_wait_clr),
        .i_inc (w_wait_inc),
        .o_cnt (w_wait_cnt)
    );

    assign w_ctl_out = reset ? CTL_RESET : w_ctl;

    assign bus.stallF   = w_ctl_out.stallF;
    assign bus.stallD   = w_ctl_out.stallD;
    assign bus.stallE   = w_ctl_out.stallE;
    assign bus.stallM   = w_ctl_out.stallM;
    assign bus.flushD   = w_ctl_out.flushD;
    assign bus.flushE   = w_ctl_out.flushE;
    assign bus.flushW   = w_ctl_out.flushW;
    assign bus.busy     = (r_state != RUN) & ~reset;
    assign bus.dmem_err = r_dmem_err & ~reset;

`ifdef PIPELINE_CTRL_PERF_EN
    // A flush is accepted whenever the data-memory hold is not in force (stallM only set then).
    logic w_flush_acc;
    assign w_flush_acc = bus.flush_req & ~w_ctl_out.stallM & ~reset;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .i_clr (reset),
        .i_inc (w_ctl_out.stallF),
        .o_cnt (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .i_clr (reset),
        .i_inc (w_flush_acc),
        .o_cnt (flush_events)
    );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed steps plus random traffic against a
// cycle-level behavioural model of the stall/flush rules.
module tb_pipeline_ctrl;

    localparam int RC      = 3;
    localparam int TIMEOUT = 64;

    logic clk;
    logic reset;

    pipeline_ctrl_if bus();

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;
`endif

    pipeline_ctrl #(
        .REDIRECT_CYCLES (RC),
        .DMEM_TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus)
`ifdef PIPELINE_CTRL_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    // Model: low-ready cycles seen in the current data-memory wait (0 = not waiting),
    // remaining flushD-only cycles of a branch window, sticky error, perf tallies.
    int m_wait    = 0;
    int m_rdr     = 0;
    bit m_err     = 1'b0;
    int m_stalls  = 0;
    int m_flushes = 0;

    task automatic step(input string tag, input bit r, input bit sr, input bit fr,
                        input bit ir, input bit dq, input bit dr);
        logic [8:0] exp_v;
        logic [8:0] obs_v;
        bit         hold;
        reset          = r;
        bus.stall_req  = sr;
        bus.flush_req  = fr;
        bus.imem_ready = ir;
        bus.dmem_req   = dq;
        bus.dmem_ready = dr;
        @(negedge clk);
        // Vector order: stallF stallD stallE stallM flushD flushE flushW busy dmem_err
        hold  = !r && ((m_wait > 0) ? !dr : (dq && !dr));
        exp_v = '0;
        if (r) begin
            exp_v = 9'b0000_111_00;
        end else begin
            if (hold)           exp_v[8:2] = 7'b1111_001;
            else if (fr)        exp_v[8:2] = 7'b0000_110;
            else if (m_rdr > 0) exp_v[8:2] = 7'b0000_100;
            else if (sr)        exp_v[8:2] = 7'b1100_010;
            else if (!ir)       exp_v[8:2] = 7'b1000_100;
            exp_v[1] = (m_wait > 0) || (m_rdr > 0);
            exp_v[0] = m_err;
        end
        obs_v = {bus.stallF, bus.stallD, bus.stallE, bus.stallM, bus.flushD, bus.flushE,
                 bus.flushW, bus.busy, bus.dmem_err};
        n_vec++;
        assert (obs_v === exp_v) else begin
            n_mis++;
            $error("FAIL %s: observed %b expected %b", tag, obs_v, exp_v);
        end
`ifdef PIPELINE_CTRL_PERF_EN
        n_vec++;
        assert (stall_cycles === 32'(m_stalls)) else begin
            n_mis++;
            $error("FAIL %s_stall_cycles: observed %0d expected %0d", tag, stall_cycles, m_stalls);
        end
        n_vec++;
        assert (flush_events === 32'(m_flushes)) else begin
            n_mis++;
            $error("FAIL %s_flush_events: observed %0d expected %0d", tag, flush_events, m_flushes);
        end
`endif
        @(posedge clk);
        if (r) begin
            m_wait    = 0;
            m_rdr     = 0;
            m_err     = 1'b0;
            m_stalls  = 0;
            m_flushes = 0;
        end else begin
            if (exp_v[8]) m_stalls++;
            if (fr && !hold) m_flushes++;
            if (hold) begin
                if (m_wait == 0) begin
                    m_wait = 1;
                    m_rdr  = 0;
                end else if (m_wait < TIMEOUT) begin
                    m_wait++;
                end
                if (m_wait == TIMEOUT) m_err = 1'b1;
            end else begin
                m_wait = 0;
                if (fr)             m_rdr = RC - 1;
                else if (m_rdr > 0) m_rdr--;
            end
        end
        #1;
    endtask

    initial begin
        bit r, sr, fr, ir, dq, dr;
        reset          = 1'b1;
        bus.stall_req  = 1'b0;
        bus.flush_req  = 1'b0;
        bus.imem_ready = 1'b1;
        bus.dmem_req   = 1'b0;
        bus.dmem_ready = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) step("reset", 1, 0, 0, 1, 0, 0);
        step("idle", 0, 0, 0, 1, 0, 0);
        step("idle", 0, 0, 0, 1, 0, 0);

        step("load_use", 0, 1, 0, 1, 0, 0);
        step("after_stall", 0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 5; i++) step("dmem_wait", 0, 0, 1, 1, 1, 0);
        step("dmem_release", 0, 0, 1, 1, 1, 1);
        for (int i = 0; i < 3; i++) step("post_release", 0, 0, 0, 1, 0, 0);

        step("branch", 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step("redirect", 0, 0, 0, 1, 0, 0);

        step("imem_miss", 0, 0, 0, 0, 0, 0);
        step("imem_miss", 0, 0, 0, 0, 0, 0);
        step("dmem_lat0", 0, 0, 0, 1, 1, 1);

        step("flush_over_stall", 0, 1, 1, 1, 0, 0);
        step("redir_stall", 0, 1, 0, 1, 0, 0);
        step("redir_to_dmem", 0, 0, 0, 1, 1, 0);
        step("redir_dmem_rel", 0, 0, 0, 1, 1, 1);
        step("idle", 0, 0, 0, 1, 0, 0);

        step("branch", 0, 0, 1, 1, 0, 0);
        step("re_branch", 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step("re_redirect", 0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 70; i++) step("timeout", 0, 0, 0, 1, 1, 0);
        step("timeout_release", 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) step("err_sticky", 0, 0, 0, 1, 0, 0);
        step("err_reset", 1, 0, 0, 1, 0, 0);
        step("err_cleared", 0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 3; i++) step("wait_abort", 0, 0, 0, 1, 1, 0);
        step("abort_reset", 1, 0, 0, 1, 1, 0);
        step("after_abort", 0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            sr = ($urandom_range(0, 3) == 0);
            fr = ($urandom_range(0, 7) == 0);
            ir = ($urandom_range(0, 4) != 0);
            dq = ($urandom_range(0, 2) == 0);
            dr = ($urandom_range(0, 2) != 0);
            step("random", r, sr, fr, ir, dq, dr);
        end

        step("perf_reset", 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step("perf_stall", 0, 1, 0, 1, 0, 0);
            step("perf_gap", 0, 0, 0, 1, 0, 0);
        end
        for (int i = 0; i < 2; i++) begin
            step("perf_flush", 0, 0, 1, 1, 0, 0);
            for (int j = 0; j < 3; j++) step("perf_gap", 0, 0, 0, 1, 0, 0);
        end
`ifdef PIPELINE_CTRL_PERF_EN
        n_vec++;
        assert (stall_cycles === 32'd4) else begin
            n_mis++;
            $error("FAIL perf_total_stalls: observed %0d expected 4", stall_cycles);
        end
        n_vec++;
        assert (flush_events === 32'd2) else begin
            n_mis++;
            $error("FAIL perf_total_flushes: observed %0d expected 2", flush_events);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
